regfile_wb_scheduler: RTL and testbench

Write-back scheduler for the 16 x 16-bit register file. It shares the file's single write port between the ALU and the load unit using round-robin arbitration with valid/ready handshakes. It keeps a pending-write scoreboard so decode can stall on RAW and WAW hazards. It sits between the execute/memory stages and the register file's `wR` / `writeEnable` / `datain` inputs.

---
 rtl/regfile_wb_scheduler.sv | 115 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: round-robin share of the register file write port
// between ALU and load unit, plus a pending-write scoreboard for hazard stalls.
module regfile_wb_scheduler #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_rd,
  input  logic [DW-1:0]   ld_data,
  output logic            ld_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic [AW-1:0]   rd_a,
  input  logic [AW-1:0]   rd_b,
  output logic            busy_a,
  output logic            busy_b,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wr,
  output logic [DW-1:0]   rf_wdata,
  output logic [NREG-1:0] pending,
  output logic            wb_err
);

  logic            prio_r;
  logic            rf_we_r;
  logic [AW-1:0]   rf_wr_r;
  logic [DW-1:0]   rf_wdata_r;
  logic [NREG-1:0] pending_r;
  logic            wb_err_r;

  logic            alu_gnt_s;
  logic            ld_gnt_s;
  logic            issue_ok_s;
  logic [NREG-1:0] pending_next_s;

  // Arbitration and hazard lookups; all grants are held low during reset.
  always_comb begin
    alu_gnt_s  = 1'b0;
    ld_gnt_s   = 1'b0;
    issue_ok_s = 1'b0;
    if (rst_n) begin
      alu_gnt_s  = alu_valid && (!ld_valid || !prio_r);
      ld_gnt_s   = ld_valid && (!alu_valid || prio_r);
      issue_ok_s = !pending_r[issue_rd];
    end else begin
      alu_gnt_s  = 1'b0;
      ld_gnt_s   = 1'b0;
      issue_ok_s = 1'b0;
    end
  end

  // Scoreboard update: clear on commit, set on issue (never the same index).
  always_comb begin
    pending_next_s = pending_r;
    if (rf_we_r) begin
      pending_next_s[rf_wr_r] = 1'b0;
    end else begin
      pending_next_s = pending_next_s;
    end
    if (issue_valid && issue_ok_s) begin
      pending_next_s[issue_rd] = 1'b1;
    end else begin
      pending_next_s = pending_next_s;
    end
  end

  // Write stage, priority pointer, scoreboard and sticky error register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_r     <= 1'b0;
      rf_we_r    <= 1'b0;
      rf_wr_r    <= {AW{1'b0}};
      rf_wdata_r <= {DW{1'b0}};
      pending_r  <= {NREG{1'b0}};
      wb_err_r   <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      if (alu_gnt_s) begin
        rf_we_r    <= 1'b1;
        rf_wr_r    <= alu_rd;
        rf_wdata_r <= alu_data;
        prio_r     <= 1'b1;
        if (!pending_r[alu_rd]) wb_err_r <= 1'b1;
      end else if (ld_gnt_s) begin
        rf_we_r    <= 1'b1;
        rf_wr_r    <= ld_rd;
        rf_wdata_r <= ld_data;
        prio_r     <= 1'b0;
        if (!pending_r[ld_rd]) wb_err_r <= 1'b1;
      end else begin
        rf_we_r <= 1'b0;
      end
    end
  end

  assign alu_ready   = alu_gnt_s;
  assign ld_ready    = ld_gnt_s;
  assign issue_ready = issue_ok_s;
  assign busy_a      = pending_r[rd_a];
  assign busy_b      = pending_r[rd_b];
  assign rf_we       = rf_we_r;
  assign rf_wr       = rf_wr_r;
  assign rf_wdata    = rf_wdata_r;
  assign pending     = pending_r;
  assign wb_err      = wb_err_r;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration order, write-stage
// latency, scoreboard set/clear, hazard stalls, error flag and reset.
module tb_regfile_wb_scheduler;

  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, ld_valid, issue_valid;
  logic [AW-1:0]   alu_rd, ld_rd, issue_rd, rd_a, rd_b;
  logic [DW-1:0]   alu_data, ld_data;
  logic            alu_ready, ld_ready, issue_ready, busy_a, busy_b;
  logic            rf_we, wb_err;
  logic [AW-1:0]   rf_wr;
  logic [DW-1:0]   rf_wdata;
  logic [NREG-1:0] pending;

  int n_vec  = 0;
  int n_miss = 0;
  int alu_cnt, ld_cnt;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rd_a(rd_a), .rd_b(rd_b), .busy_a(busy_a), .busy_b(busy_b),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wdata(rf_wdata),
    .pending(pending), .wb_err(wb_err)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [AW-1:0] r);
    issue_valid = 1'b1;
    issue_rd    = r;
    step();
    issue_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 1'b1; ld_valid = 1'b1; issue_valid = 1'b0;
    alu_rd = 4'd1; ld_rd = 4'd2; alu_data = 16'h0; ld_data = 16'h0;
    issue_rd = 4'd0; rd_a = 4'd0; rd_b = 4'd0;

    // Reset with both valids high
    step(); step();
    check_value("rst_pending", pending, 32'h0);
    check_value("rst_rf_we", rf_we, 32'd0);
    check_value("rst_rf_wr", rf_wr, 32'd0);
    check_value("rst_rf_wdata", rf_wdata, 32'h0);
    check_value("rst_alu_ready", alu_ready, 32'd0);
    check_value("rst_ld_ready", ld_ready, 32'd0);
    check_value("rst_issue_ready", issue_ready, 32'd0);
    check_value("rst_wb_err", wb_err, 32'd0);

    // Single write-back to r5
    rst_n = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 4'd5; #1;
    check_value("sw_issue_ready", issue_ready, 32'd1);
    step(); issue_valid = 1'b0; rd_a = 4'd5; rd_b = 4'd6; #1;
    check_value("sw_pending_set", pending, 32'h0020);
    check_value("sw_busy_a_set", busy_a, 32'd1);
    check_value("sw_busy_b_clr", busy_b, 32'd0);
    check_value("sw_waw_stall", issue_ready, 32'd0);
    alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 16'hBEEF; #1;
    check_value("sw_alu_ready", alu_ready, 32'd1);
    check_value("sw_ld_ready", ld_ready, 32'd0);
    step(); alu_valid = 1'b0;
    check_value("sw_rf_we", rf_we, 32'd1);
    check_value("sw_rf_wr", rf_wr, 32'd5);
    check_value("sw_rf_wdata", rf_wdata, 32'hBEEF);
    check_value("sw_pending_hold", pending, 32'h0020);
    check_value("sw_busy_a_hold", busy_a, 32'd1);
    step();
    check_value("sw_rf_we_low", rf_we, 32'd0);
    check_value("sw_pending_clr", pending, 32'h0);
    check_value("sw_busy_a_clr", busy_a, 32'd0);
    check_value("sw_rf_wr_hold", rf_wr, 32'd5);
    check_value("sw_rf_wdata_hold", rf_wdata, 32'hBEEF);
    check_value("sw_wb_err", wb_err, 32'd0);

    // Contention from reset: ALU first, then load
    rst_n = 1'b0; step(); rst_n = 1'b1;
    issue(4'd1); issue(4'd2);
    check_value("ct_pending", pending, 32'h0006);
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'h1111;
    ld_valid  = 1'b1; ld_rd  = 4'd2; ld_data  = 16'h2222; #1;
    check_value("ct_alu_first", alu_ready, 32'd1);
    check_value("ct_ld_wait", ld_ready, 32'd0);
    step(); alu_valid = 1'b0; #1;
    check_value("ct_ld_next", ld_ready, 32'd1);
    check_value("ct_alu_idle", alu_ready, 32'd0);
    check_value("ct_wr1", rf_wr, 32'd1);
    check_value("ct_data1", rf_wdata, 32'h1111);
    step(); ld_valid = 1'b0;
    check_value("ct_wr2", rf_wr, 32'd2);
    check_value("ct_data2", rf_wdata, 32'h2222);
    check_value("ct_pending_r1clr", pending, 32'h0004);
    step();
    check_value("ct_pending_clr", pending, 32'h0);
    check_value("ct_wb_err", wb_err, 32'd0);

    // Sustained contention on r8..r13: ALU takes even, load odd registers
    for (int r = 8; r < 14; r++) issue(AW'(r));
    check_value("sc_pending", pending, 32'h3F00);
    alu_cnt = 0; ld_cnt = 0;
    alu_valid = 1'b1; alu_rd = 4'd8; alu_data = 16'hA008;
    ld_valid  = 1'b1; ld_rd  = 4'd9; ld_data  = 16'hB009;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_value($sformatf("sc_alu_ready_%0d", i), alu_ready, ((i % 2) == 0) ? 32'd1 : 32'd0);
      check_value($sformatf("sc_ld_ready_%0d", i), ld_ready, ((i % 2) == 1) ? 32'd1 : 32'd0);
      if (alu_ready) alu_cnt++;
      if (ld_ready) ld_cnt++;
      step();
      check_value($sformatf("sc_rf_wr_%0d", i), rf_wr, 32'(8 + i));
      if ((i % 2) == 0) begin
        alu_rd = alu_rd + 4'd2; alu_data = alu_data + 16'd2;
        if (alu_cnt == 3) alu_valid = 1'b0;
      end else begin
        ld_rd = ld_rd + 4'd2; ld_data = ld_data + 16'd2;
        if (ld_cnt == 3) ld_valid = 1'b0;
      end
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    check_value("sc_alu_grants", alu_cnt, 32'd3);
    check_value("sc_ld_grants", ld_cnt, 32'd3);
    step();
    check_value("sc_pending_clr", pending, 32'h0);
    check_value("sc_wb_err", wb_err, 32'd0);

    // WAW stall on r7, r8 still issuable
    issue(4'd7);
    issue_valid = 1'b1; issue_rd = 4'd7; #1;
    check_value("waw_stall", issue_ready, 32'd0);
    step();
    check_value("waw_no_change", pending, 32'h0080);
    issue_rd = 4'd8; #1;
    check_value("waw_other_ok", issue_ready, 32'd1);
    step(); issue_valid = 1'b0;
    check_value("waw_pending2", pending, 32'h0180);
    alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 16'h7777;
    step(); alu_valid = 1'b0; issue_rd = 4'd7; #1;
    check_value("waw_stall_we", issue_ready, 32'd0);
    step();
    check_value("waw_release", issue_ready, 32'd1);
    check_value("waw_pending3", pending, 32'h0100);
    ld_valid = 1'b1; ld_rd = 4'd8; ld_data = 16'h8888;
    step(); ld_valid = 1'b0; step();
    check_value("waw_pending_clr", pending, 32'h0);

    // Error on non-pending write, then reset during the write stage
    issue(4'd4);
    ld_valid = 1'b1; ld_rd = 4'd3; ld_data = 16'h3333; #1;
    check_value("err_ld_ready", ld_ready, 32'd1);
    step();
    check_value("err_flag", wb_err, 32'd1);
    check_value("err_rf_we", rf_we, 32'd1);
    check_value("err_rf_wr", rf_wr, 32'd3);
    check_value("err_rf_wdata", rf_wdata, 32'h3333);
    rst_n = 1'b0; alu_valid = 1'b1; #1;
    check_value("err_rst_ld_ready", ld_ready, 32'd0);
    check_value("err_rst_alu_ready", alu_ready, 32'd0);
    step();
    check_value("err_rst_rf_we", rf_we, 32'd0);
    check_value("err_rst_wb_err", wb_err, 32'd0);
    check_value("err_rst_pending", pending, 32'h0);
    check_value("err_rst_rf_wr", rf_wr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
